// File: rtl/dmem_axi_responder.sv
// dmem_axi_responder: AXI4-Lite 64-bit data-memory slave, one transaction at a time; DMEM_ACC_CNT_EN adds access counters
module dmem_axi_responder #(
    parameter int ADDR_W = 64,
    parameter int DEPTH = 4096,
    parameter logic [ADDR_W-1:0] BASE = 'h8000_0000,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp
`ifdef DMEM_ACC_CNT_EN
    ,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
    output logic [15:0]       err_cnt
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * 8);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_RESP} state_t;

    state_t state, state_nx;
    logic [63:0] mem [DEPTH];
    logic pri;
    logic aw_got, w_got;
    logic [ADDR_W-1:0] aw_q;
    logic [63:0] w_q;
    logic [7:0] s_q;
    logic [31:0] cnt;
    logic req_wr, grant_rd, grant_wr, wr_act;
    logic ar_hs, aw_hs, w_hs, commit;
    logic [ADDR_W-1:0] cur_addr;
    logic [63:0] cur_data;
    logic [7:0] cur_strb;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a >= BASE && (a - BASE) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 3);
    endfunction

    // pri=0 favours reads, pri=1 favours writes on a collision
    assign req_wr = awvalid || wvalid;
    assign grant_rd = arvalid && !(req_wr && pri);
    assign grant_wr = req_wr && !(arvalid && !pri);
    assign wr_act = !reset && ((state == IDLE && grant_wr) || state == WR_COLLECT);
    assign arready = !reset && state == IDLE && grant_rd;
    assign awready = wr_act && !aw_got;
    assign wready = wr_act && !w_got;
    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs = wvalid && wready;
    assign cur_addr = aw_got ? aw_q : awaddr;
    assign cur_data = w_got ? w_q : wdata;
    assign cur_strb = w_got ? s_q : wstrb;
    assign commit = (aw_got || aw_hs) && (w_got || w_hs) && (aw_hs || w_hs);
    assign rvalid = state == RD_RESP;
    assign bvalid = state == WR_RESP;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = ar_hs ? (RD_LAT == 1 ? RD_RESP : RD_WAIT) :
                                   commit ? WR_RESP : grant_wr ? WR_COLLECT : IDLE;
            RD_WAIT:    state_nx = cnt == '0 ? RD_RESP : RD_WAIT;
            RD_RESP:    state_nx = rready ? IDLE : RD_RESP;
            WR_COLLECT: state_nx = commit ? WR_RESP : WR_COLLECT;
            WR_RESP:    state_nx = bready ? IDLE : WR_RESP;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pri <= 1'b0;
            aw_got <= 1'b0;
            w_got <= 1'b0;
            rdata <= '0;
            rresp <= 2'b00;
            bresp <= 2'b00;
            cnt <= '0;
        end else begin
            if (state == IDLE && (grant_rd || grant_wr)) pri <= !pri;
            if (ar_hs) begin
                rdata <= in_range(araddr) ? mem[idx_of(araddr)] : '0;
                rresp <= in_range(araddr) ? 2'b00 : 2'b10;
                cnt <= 32'(RD_LAT - 2);
            end
            if (state == RD_WAIT) cnt <= cnt - 1;
            aw_got <= !commit && (aw_got || aw_hs);
            w_got <= !commit && (w_got || w_hs);
            if (aw_hs) aw_q <= awaddr;
            if (w_hs) begin
                w_q <= wdata;
                s_q <= wstrb;
            end
            if (commit) bresp <= in_range(cur_addr) ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && commit && in_range(cur_addr))
            for (int k = 0; k < 8; k++)
                if (cur_strb[k]) mem[idx_of(cur_addr)][8*k +: 8] <= cur_data[8*k +: 8];
    end

`ifdef DMEM_ACC_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            err_cnt <= '0;
        end else begin
            rd_cnt <= rd_cnt + 32'(rvalid && rready);
            wr_cnt <= wr_cnt + 32'(bvalid && bready);
            err_cnt <= err_cnt + 16'((rvalid && rready && rresp[1]) || (bvalid && bready && bresp[1]));
        end
    end
`endif
endmodule

// File: tb/tb_dmem_axi_responder.sv
// tb_dmem_axi_responder: scoreboard bench for dmem_axi_responder with RD_LAT=2
module tb_dmem_axi_responder;
    localparam int LAT = 2;
    localparam int DEPTH = 4096;
    localparam logic [63:0] BASE = 64'h8000_0000;

    typedef struct packed {
        logic [1:0]  resp;
        logic [63:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [63:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0] wstrb = '0;
    logic [1:0] bresp, rresp;
`ifdef DMEM_ACC_CNT_EN
    logic [31:0] rd_cnt, wr_cnt;
    logic [15:0] err_cnt;
`endif

    int errors = 0, checks = 0;
    int n_rd = 0, n_wr = 0, n_err = 0;
    logic [63:0] model [int];
    logic [1:0] exp_b [$];
    rexp_t exp_r [$];

    dmem_axi_responder #(.ADDR_W(64), .DEPTH(DEPTH), .BASE(BASE), .RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
`ifdef DMEM_ACC_CNT_EN
        , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic in_rng(input logic [63:0] a);
        return a >= BASE && a < BASE + 64'(DEPTH * 8);
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic void model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] w;
        if (!in_rng(a)) return;
        w = model.exists(widx(a)) ? model[widx(a)] : '0;
        for (int k = 0; k < 8; k++) if (s[k]) w[8*k +: 8] = d[8*k +: 8];
        model[widx(a)] = w;
    endfunction

    function automatic rexp_t model_read(input logic [63:0] a);
        rexp_t e;
        e.resp = in_rng(a) ? 2'b00 : 2'b10;
        e.data = (in_rng(a) && model.exists(widx(a))) ? model[widx(a)] : '0;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // call at the negedge just after the commit edge
    task automatic collect_b();
        int n;
        logic [1:0] e;
        bready = 1'b1;
        #1;
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL b_latency: bvalid=%b required 1 one cycle after commit", bvalid);
        end
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        e = exp_b.pop_front();
        checks++;
        if (bvalid !== 1'b1 || bresp !== e) begin
            errors++;
            $display("FAIL bresp: bvalid=%b bresp=%b required bvalid=1 bresp=%b", bvalid, bresp, e);
        end
        n_wr++;
        if (e[1]) n_err++;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // call at the negedge just after the AR handshake edge
    task automatic collect_r(input int hold);
        int lat;
        rexp_t e;
        lat = 1;
        #1;
        while (!rvalid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL r_latency: rvalid after %0d cycles required %0d", lat, LAT);
        end
        e = exp_r.pop_front();
        checks++;
        if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp) begin
            errors++;
            $display("FAIL rdata: rvalid=%b rdata=%h rresp=%b required 1 %h %b", rvalid, rdata, rresp, e.data, e.resp);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp) begin
                errors++;
                $display("FAIL r_hold: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, e.data);
            end
        end
        n_rd++;
        if (e.resp[1]) n_err++;
        @(negedge clk);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int n;
        logic ah, wh;
        exp_b.push_back(in_rng(a) ? 2'b00 : 2'b10);
        model_write(a, d, s);
        @(negedge clk);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            #1;
            ah = awvalid && awready;
            wh = wvalid && wready;
            @(negedge clk);
            if (ah) awvalid = 1'b0;
            if (wh) wvalid = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            $display("FAIL wr_handshake: awvalid=%b wvalid=%b still pending", awvalid, wvalid);
            $fatal(1, "write handshake timeout");
        end
        collect_b();
    endtask

    task automatic rd(input logic [63:0] a, input int hold);
        int n;
        logic ah;
        exp_r.push_back(model_read(a));
        @(negedge clk);
        arvalid = 1'b1; araddr = a;
        n = 0;
        while (arvalid && n < 20) begin
            #1;
            ah = arready;
            @(negedge clk);
            if (ah) arvalid = 1'b0;
            n++;
        end
        if (arvalid) begin
            $display("FAIL rd_handshake: arready never asserted");
            $fatal(1, "read handshake timeout");
        end
        collect_r(hold);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: aw/w/ar ready=%b%b%b bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h required all 0",
                     awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
        end
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        wr(64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        rd(64'h8000_0010, 0);
    endtask

    task automatic test_strobe();
        wr(64'h8000_0020, 64'h0, 8'hFF);
        wr(64'h8000_0022, 64'h0000_0000_00AB_0000, 8'h04);
        rd(64'h8000_0020, 0);
        wr(64'h8000_0020, 64'h1111_2222_3333_4444, 8'h81);
        rd(64'h8000_0027, 0);
    endtask

    task automatic test_w_before_aw();
        exp_b.push_back(2'b00);
        model_write(64'h8000_0030, 64'h0123_4567_89AB_CDEF, 8'hFF);
        @(negedge clk);
        wvalid = 1'b1; wdata = 64'h0123_4567_89AB_CDEF; wstrb = 8'hFF;
        #1;
        checks++;
        if (wready !== 1'b1 || awready !== 1'b1) begin
            errors++;
            $display("FAIL w_first_grant: wready=%b awready=%b required 1 1", wready, awready);
        end
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
                errors++;
                $display("FAIL w_first_wait: wready=%b awready=%b bvalid=%b required 0 1 0", wready, awready, bvalid);
            end
            @(negedge clk);
        end
        awvalid = 1'b1; awaddr = 64'h8000_0030;
        @(negedge clk);
        awvalid = 1'b0;
        collect_b();
        rd(64'h8000_0030, 0);
    endtask

    task automatic test_slverr();
        wr(BASE + 64'((DEPTH - 1) * 8), 64'h5A5A_A5A5_0F0F_F0F0, 8'hFF);
        rd(64'h7FFF_FFF8, 0);
        wr(BASE + 64'(DEPTH * 8), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        rd(BASE + 64'((DEPTH - 1) * 8), 0);
`ifdef DMEM_ACC_CNT_EN
        #1;
        checks++;
        if (rd_cnt !== 32'(n_rd) || wr_cnt !== 32'(n_wr) || err_cnt !== 16'(n_err)) begin
            errors++;
            $display("FAIL counters: rd=%0d wr=%0d err=%0d required %0d %0d %0d", rd_cnt, wr_cnt, err_cnt, n_rd, n_wr, n_err);
        end
`endif
    endtask

    task automatic test_arbitration();
        int n;
        rexp_t e;
        do_reset();
        exp_r.push_back(model_read(64'h8000_0010));
        exp_b.push_back(2'b00);
        model_write(64'h8000_0040, 64'h1122_3344_5566_7788, 8'hFF);
        @(negedge clk);
        arvalid = 1'b1; araddr = 64'h8000_0010;
        awvalid = 1'b1; awaddr = 64'h8000_0040; wvalid = 1'b1; wdata = 64'h1122_3344_5566_7788; wstrb = 8'hFF;
        #1;
        checks++;
        if (arready !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL arb_first: arready=%b awready=%b wready=%b required 1 0 0", arready, awready, wready);
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        #1;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        e = exp_r.pop_front();
        checks++;
        if (rvalid !== 1'b1 || rdata !== e.data) begin
            errors++;
            $display("FAIL arb_rdata: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, e.data);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rvalid !== 1'b1 || rdata !== e.data || awready !== 1'b0) begin
                errors++;
                $display("FAIL arb_stall: rvalid=%b rdata=%h awready=%b required 1 %h 0", rvalid, rdata, awready, e.data);
            end
        end
        @(negedge clk);
        rready = 1'b1;
        arvalid = 1'b1; araddr = 64'h8000_0040;
        exp_r.push_back(model_read(64'h8000_0040));
        @(negedge clk);
        rready = 1'b0;
        #1;
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b0) begin
            errors++;
            $display("FAIL arb_second: awready=%b wready=%b arready=%b required 1 1 0", awready, wready, arready);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        collect_b();
        n = 0;
        while (arvalid && n < 20) begin
            #1;
            e.resp[0] = arready;
            @(negedge clk);
            if (e.resp[0]) arvalid = 1'b0;
            n++;
        end
        checks++;
        if (arvalid) begin
            errors++;
            arvalid = 1'b0;
            $display("FAIL arb_third: arready=0 required 1 after write");
        end else collect_r(0);
    endtask

    task automatic test_reset_mid();
        model_write(64'h8000_0050, 64'hCAFE_0000_BABE_1111, 8'hFF);
        @(negedge clk);
        awvalid = 1'b1; awaddr = 64'h8000_0050; wvalid = 1'b1; wdata = 64'hCAFE_0000_BABE_1111; wstrb = 8'hFF;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_bvalid: bvalid=%b required 1", bvalid);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_b: bvalid=%b required 0", bvalid);
        end
        @(negedge clk);
        wvalid = 1'b1; wdata = 64'h0; wstrb = 8'hFF;
        @(negedge clk);
        wvalid = 1'b0;
        awvalid = 1'b1; awaddr = 64'h8000_0050; reset = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; reset = 1'b0;
        #1;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL commit_reset_b: bvalid=%b required 0", bvalid);
        end
        rd(64'h8000_0050, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_w_before_aw();
        test_slverr();
        test_arbitration();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
